// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared types and defaults for the video write queue
package video_pkg;

  localparam int          FIFO_DEPTH_DEF   = 8;
  localparam int          SCREEN_CELLS_DEF = 1200;
  localparam logic [15:0] BLANK_CHAR_DEF   = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } vwq_state_t;

  typedef struct packed {
    logic [15:0] pos;
    logic [15:0] data;
  } vwq_entry_t;

endpackage

// File: rtl/vwq_fifo.sv
// rtl/vwq_fifo.sv - synchronous character-write queue with flush
module vwq_fifo
  import video_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  vwq_entry_t wdata,
  input  logic       pop,
  input  logic       flush,
  output vwq_entry_t rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  vwq_entry_t    mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW-1:0] wr_idx;

  // A flush rewinds both pointers; a push in the same cycle lands in slot 0.
  assign wr_idx = flush ? '0 : wr_ptr[AW-1:0];

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Pointer update: flush wins over pop, and keeps a same-cycle push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= push ? (AW+1)'(1) : '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= wdata;
  end

endmodule

// File: rtl/video_write_queue.sv
// rtl/video_write_queue.sv - queues CPU character writes and screen clears into video RAM
module video_write_queue
  import video_pkg::*;
#(
  parameter int          FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int          SCREEN_CELLS = SCREEN_CELLS_DEF,
  parameter logic [15:0] BLANK_CHAR   = BLANK_CHAR_DEF
) (
  input  logic        wire_clock,
  input  logic        wire_reset,
  input  logic        videoflag,
  input  logic [15:0] bus_vga_pos,
  input  logic [15:0] bus_vga_char,
  input  logic        clear_req,
  input  logic        vram_ready,
  output logic        vram_we,
  output logic [15:0] vram_addr,
  output logic [15:0] vram_data,
  output logic        fifo_full,
  output logic        busy,
  output logic        overflow,
  output logic        range_err
);

  vwq_state_t  state, state_next;
  logic        flag_q;
  logic        edge_arm;
  logic        req;
  logic        in_range;
  logic        push, pop, clr_issue;
  logic        drop_full, drop_range;
  logic        fifo_empty;
  logic [15:0] clr_cnt;
  vwq_entry_t  head;

  // edge_arm stays low for the first clock after reset so a videoflag that is
  // already high at release only loads flag_q and is not taken as a request.
  assign req      = edge_arm & videoflag & ~flag_q;
  assign in_range = (bus_vga_pos < 16'(SCREEN_CELLS));

  // A flush frees the whole queue, so a clear cycle always has room for the request.
  assign push       = req & in_range & (~fifo_full | pop | clear_req);
  assign drop_full  = req & in_range & fifo_full & ~pop & ~clear_req;
  assign drop_range = req & ~in_range;

  assign busy = ~fifo_empty | (state == ST_CLEAR);

  vwq_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wire_clock),
    .rst_n (wire_reset),
    .push  (push),
    .wdata ('{pos: bus_vga_pos, data: bus_vga_char}),
    .pop   (pop),
    .flush (clear_req),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Videoflag edge detector with its post-reset arming bit.
  always_ff @(posedge wire_clock or negedge wire_reset) begin
    if (!wire_reset) begin
      flag_q   <= 1'b0;
      edge_arm <= 1'b0;
    end else begin
      flag_q   <= videoflag;
      edge_arm <= 1'b1;
    end
  end

  // State register and clear address counter.
  always_ff @(posedge wire_clock or negedge wire_reset) begin
    if (!wire_reset) begin
      state   <= ST_IDLE;
      clr_cnt <= '0;
    end else begin
      state <= state_next;
      if (clear_req)      clr_cnt <= '0;
      else if (clr_issue) clr_cnt <= clr_cnt + 16'd1;
    end
  end

  // Next state plus the pop / clear-issue strobes; clear_req overrides everything.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    clr_issue  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (push || !fifo_empty) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        pop = ~fifo_empty & vram_ready & ~clear_req;
        if (fifo_empty && !push) state_next = ST_IDLE;
      end
      ST_CLEAR: begin
        clr_issue = vram_ready & ~clear_req;
        if (clr_issue && clr_cnt == 16'(SCREEN_CELLS - 1))
          state_next = (!fifo_empty || push) ? ST_DRAIN : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (clear_req) state_next = ST_CLEAR;
  end

  // Registered video RAM write port; address and data hold between writes.
  always_ff @(posedge wire_clock or negedge wire_reset) begin
    if (!wire_reset) begin
      vram_we   <= 1'b0;
      vram_addr <= '0;
      vram_data <= '0;
    end else begin
      vram_we <= pop | clr_issue;
      if (pop) begin
        vram_addr <= head.pos;
        vram_data <= head.data;
      end else if (clr_issue) begin
        vram_addr <= clr_cnt;
        vram_data <= BLANK_CHAR;
      end
    end
  end

  // Sticky drop flags, cleared by a screen clear.
  always_ff @(posedge wire_clock or negedge wire_reset) begin
    if (!wire_reset) begin
      overflow  <= 1'b0;
      range_err <= 1'b0;
    end else begin
      overflow  <= (overflow  & ~clear_req) | drop_full;
      range_err <= (range_err & ~clear_req) | drop_range;
    end
  end

endmodule

// File: tb/tb_video_write_queue.sv
// tb/tb_video_write_queue.sv - scoreboard bench for video_write_queue
module tb_video_write_queue;

  logic        wire_clock = 1'b0;
  logic        wire_reset;
  logic        videoflag;
  logic [15:0] bus_vga_pos;
  logic [15:0] bus_vga_char;
  logic        clear_req;
  logic        vram_ready;
  logic        vram_we;
  logic [15:0] vram_addr;
  logic [15:0] vram_data;
  logic        fifo_full;
  logic        busy;
  logic        overflow;
  logic        range_err;

  localparam int          CELLS = 1200;
  localparam logic [15:0] BLANK = 16'h0000;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_writes = 0;
  int          w0;
  logic [31:0] sb [$];

  video_write_queue dut (
    .wire_clock   (wire_clock),
    .wire_reset   (wire_reset),
    .videoflag    (videoflag),
    .bus_vga_pos  (bus_vga_pos),
    .bus_vga_char (bus_vga_char),
    .clear_req    (clear_req),
    .vram_ready   (vram_ready),
    .vram_we      (vram_we),
    .vram_addr    (vram_addr),
    .vram_data    (vram_data),
    .fifo_full    (fifo_full),
    .busy         (busy),
    .overflow     (overflow),
    .range_err    (range_err)
  );

  always #5 wire_clock = ~wire_clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Every write leaving the DUT is matched against the head of the scoreboard.
  always @(negedge wire_clock) begin
    logic [31:0] e;
    if (vram_we === 1'b1) begin
      n_writes++;
      if (sb.size() == 0) begin
        check("unexpected_we", {31'd0, vram_we}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("wr_addr", {16'd0, vram_addr}, {16'd0, e[31:16]});
        check("wr_data", {16'd0, vram_data}, {16'd0, e[15:0]});
      end
    end
  end

  task automatic send(input logic [15:0] p, input logic [15:0] d);
    @(negedge wire_clock);
    bus_vga_pos  = p;
    bus_vga_char = d;
    videoflag    = 1'b1;
    @(negedge wire_clock);
    videoflag    = 1'b0;
  endtask

  task automatic push_blanks();
    for (int a = 0; a < CELLS; a++) sb.push_back({16'(a), BLANK});
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int n = 0;
    while ((busy !== 1'b0 || sb.size() != 0) && n < max_cycles) begin
      @(negedge wire_clock);
      n++;
    end
    check(tag, sb.size(), 0);
  endtask

  task automatic pulse_clear();
    @(negedge wire_clock);
    clear_req = 1'b1;
    push_blanks();
    @(negedge wire_clock);
    clear_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    wire_reset   = 1'b0;
    videoflag    = 1'b0;
    bus_vga_pos  = '0;
    bus_vga_char = '0;
    clear_req    = 1'b0;
    vram_ready   = 1'b1;
    repeat (3) @(negedge wire_clock);
    check("rst_we",     {31'd0, vram_we},   32'd0);
    check("rst_addr",   {16'd0, vram_addr}, 32'd0);
    check("rst_busy",   {31'd0, busy},      32'd0);
    check("rst_full",   {31'd0, fifo_full}, 32'd0);
    check("rst_ovf",    {31'd0, overflow},  32'd0);
    check("rst_rng",    {31'd0, range_err}, 32'd0);
    wire_reset = 1'b1;
    repeat (2) @(negedge wire_clock);

    // single write, two-cycle latency
    sb.push_back({16'd5, 16'h0141});
    @(negedge wire_clock);
    bus_vga_pos = 16'd5; bus_vga_char = 16'h0141; videoflag = 1'b1;
    @(negedge wire_clock);
    videoflag = 1'b0;
    check("t1_we_edge1", {31'd0, vram_we}, 32'd0);
    @(negedge wire_clock);
    check("t1_we_edge2", {31'd0, vram_we}, 32'd1);
    check("t1_addr", {16'd0, vram_addr}, 32'd5);
    check("t1_data", {16'd0, vram_data}, 32'h0141);
    @(negedge wire_clock);
    check("t1_hold_addr", {16'd0, vram_addr}, 32'd5);
    wait_idle("t1_drain", 20);

    // held-high videoflag gives one write
    w0 = n_writes;
    sb.push_back({16'd7, 16'h1234});
    @(negedge wire_clock);
    bus_vga_pos = 16'd7; bus_vga_char = 16'h1234; videoflag = 1'b1;
    repeat (10) @(negedge wire_clock);
    videoflag = 1'b0;
    repeat (5) @(negedge wire_clock);
    check("t2_one_write", n_writes - w0, 1);
    wait_idle("t2_drain", 20);

    // fill with ready low, ninth request overflows
    vram_ready = 1'b0;
    w0 = n_writes;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) sb.push_back({16'(10 + i), 16'(16'hA000 + i)});
      send(16'(10 + i), 16'(16'hA000 + i));
      if (i == 6) check("t3_not_full7", {31'd0, fifo_full}, 32'd0);
      if (i == 7) begin
        check("t3_full8", {31'd0, fifo_full}, 32'd1);
        check("t3_no_ovf8", {31'd0, overflow}, 32'd0);
      end
    end
    check("t3_ovf", {31'd0, overflow}, 32'd1);
    repeat (10) @(negedge wire_clock);
    check("t3_held", n_writes - w0, 0);
    check("t3_busy", {31'd0, busy}, 32'd1);
    vram_ready = 1'b1;
    wait_idle("t3_drain", 40);
    check("t3_count", n_writes - w0, 8);
    check("t3_ovf_sticky", {31'd0, overflow}, 32'd1);

    // out-of-range position, then a clear wipes both flags
    w0 = n_writes;
    send(16'd1200, 16'h5555);
    repeat (5) @(negedge wire_clock);
    check("t4_no_write", n_writes - w0, 0);
    check("t4_rng", {31'd0, range_err}, 32'd1);
    pulse_clear();
    check("t4_rng_clr", {31'd0, range_err}, 32'd0);
    check("t4_ovf_clr", {31'd0, overflow}, 32'd0);
    wait_idle("t4_clear_done", 1400);

    // clear discards queued entries; mid-clear request follows address 1199
    vram_ready = 1'b0;
    w0 = n_writes;
    for (int i = 0; i < 3; i++) send(16'(100 + i), 16'(16'hC000 + i));
    @(negedge wire_clock);
    clear_req  = 1'b1;
    vram_ready = 1'b1;
    push_blanks();
    @(negedge wire_clock);
    clear_req = 1'b0;
    check("t5_busy", {31'd0, busy}, 32'd1);
    repeat (10) @(negedge wire_clock);
    sb.push_back({16'd300, 16'hBEEF});
    send(16'd300, 16'hBEEF);
    wait_idle("t5_done", 1500);
    check("t5_count", n_writes - w0, CELLS + 1);

    // reset in the middle of a clear
    pulse_clear();
    repeat (50) @(negedge wire_clock);
    #2;
    wire_reset = 1'b0;
    sb.delete();
    #1;
    check("t6_we",    {31'd0, vram_we},   32'd0);
    check("t6_addr",  {16'd0, vram_addr}, 32'd0);
    check("t6_data",  {16'd0, vram_data}, 32'd0);
    check("t6_busy",  {31'd0, busy},      32'd0);
    check("t6_full",  {31'd0, fifo_full}, 32'd0);
    videoflag = 1'b1;
    repeat (3) @(negedge wire_clock);
    wire_reset = 1'b1;
    w0 = n_writes;
    repeat (20) @(negedge wire_clock);
    check("t6_no_write", n_writes - w0, 0);
    check("t6_idle", {31'd0, busy}, 32'd0);
    videoflag = 1'b0;
    repeat (2) @(negedge wire_clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
